// File: rtl/axi_lite_reg_slave.sv
// axi_lite_reg_slave
// AXI4-Lite responder holding the DMA control/status register file.
// The stored registers drive regs_o. Every committed write to a storable
// register raises a one-cycle strobe on wr_pulse_o.
// The word at STATUS_IDX is read-only and returns status_i.
// Optional feature: define AXIL_SLVERR_EN so that unmapped reads and writes
// answer with SLVERR. Without it, every access answers OKAY.
module axi_lite_reg_slave #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16,
    parameter int STATUS_IDX = 1
) (
    input  logic                           axi_aclk,
    input  logic                           axi_reset,
    input  logic                           s_axi_lite_awvalid,
    output logic                           s_axi_lite_awready,
    input  logic [ADDR_WIDTH-1:0]          s_axi_lite_awaddr,
    input  logic                           s_axi_lite_wvalid,
    output logic                           s_axi_lite_wready,
    input  logic [DATA_WIDTH-1:0]          s_axi_lite_wdata,
    output logic [1:0]                     s_axi_lite_bresp,
    output logic                           s_axi_lite_bvalid,
    input  logic                           s_axi_lite_bready,
    input  logic                           s_axi_lite_arvalid,
    output logic                           s_axi_lite_arready,
    input  logic [ADDR_WIDTH-1:0]          s_axi_lite_araddr,
    output logic                           s_axi_lite_rvalid,
    input  logic                           s_axi_lite_rready,
    output logic [DATA_WIDTH-1:0]          s_axi_lite_rdata,
    output logic [1:0]                     s_axi_lite_rresp,
    input  logic [DATA_WIDTH-1:0]          status_i,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
    output logic [NUM_REGS-1:0]            wr_pulse_o
);

    localparam int IDX_W     = ADDR_WIDTH - 2;
    localparam int REG_IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [IDX_W:0]   NUM_REGS_W = (IDX_W + 1)'(NUM_REGS);
    localparam logic [IDX_W-1:0] STATUS_W   = IDX_W'(STATUS_IDX);
    localparam logic [1:0]       RESP_OKAY  = 2'b00;
`ifdef AXIL_SLVERR_EN
    localparam logic [1:0]       RESP_UNMAPPED = 2'b10;
`else
    localparam logic [1:0]       RESP_UNMAPPED = 2'b00;
`endif

    typedef enum logic [1:0] {WR_IDLE, WR_COLLECT, WR_RESP} wr_state_t;
    typedef enum logic       {RD_IDLE, RD_RESP}             rd_state_t;

    wr_state_t wr_state_reg, wr_state_next;
    rd_state_t rd_state_reg, rd_state_next;

    logic                  aw_held_reg;
    logic                  w_held_reg;
    logic [IDX_W-1:0]      aw_idx_reg;
    logic [DATA_WIDTH-1:0] wdata_reg;
    logic [1:0]            bresp_reg;
    logic [DATA_WIDTH-1:0] rdata_reg;
    logic [1:0]            rresp_reg;
    logic [DATA_WIDTH-1:0] regs_rd [NUM_REGS];

    logic aw_hs, w_hs, b_hs, ar_hs;
    logic wr_commit, wr_mapped, wr_writable;
    logic [IDX_W-1:0]      rd_idx;
    logic                  rd_mapped;
    logic [DATA_WIDTH-1:0] rd_value;
    logic [1:0]            rd_resp;

    // Byte-lane bits of the addresses carry no meaning for word registers.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{s_axi_lite_awaddr[1:0], s_axi_lite_araddr[1:0]};

    assign aw_hs = s_axi_lite_awvalid && s_axi_lite_awready;
    assign w_hs  = s_axi_lite_wvalid && s_axi_lite_wready;
    assign b_hs  = s_axi_lite_bvalid && s_axi_lite_bready;
    assign ar_hs = s_axi_lite_arvalid && s_axi_lite_arready;

    assign wr_commit   = (wr_state_reg == WR_COLLECT) && aw_held_reg && w_held_reg;
    assign wr_mapped   = {1'b0, aw_idx_reg} < NUM_REGS_W;
    assign wr_writable = wr_mapped && (aw_idx_reg != STATUS_W);

    // Write FSM state register
    always_ff @(posedge axi_aclk) begin
        if (axi_reset) wr_state_reg <= WR_IDLE;
        else           wr_state_reg <= wr_state_next;
    end

    // Write FSM next state: collect AW and W in any order, commit, then wait for bready
    always_comb begin
        wr_state_next = wr_state_reg;
        case (wr_state_reg)
            WR_IDLE:    if (aw_hs || w_hs) wr_state_next = WR_COLLECT;
            WR_COLLECT: if (aw_held_reg && w_held_reg) wr_state_next = WR_RESP;
            WR_RESP:    if (s_axi_lite_bready) wr_state_next = WR_IDLE;
            default:    wr_state_next = WR_IDLE;
        endcase
    end

    // Write FSM outputs: each ready stays low from its capture until the response is taken
    always_comb begin
        s_axi_lite_awready = 1'b0;
        s_axi_lite_wready  = 1'b0;
        s_axi_lite_bvalid  = 1'b0;
        case (wr_state_reg)
            WR_IDLE: begin
                s_axi_lite_awready = 1'b1;
                s_axi_lite_wready  = 1'b1;
            end
            WR_COLLECT: begin
                s_axi_lite_awready = !aw_held_reg;
                s_axi_lite_wready  = !w_held_reg;
            end
            WR_RESP: s_axi_lite_bvalid = 1'b1;
            default: ;
        endcase
    end

    // Write capture: hold AW index and W data until the response handshake
    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            aw_held_reg <= 1'b0;
            w_held_reg  <= 1'b0;
            aw_idx_reg  <= '0;
            wdata_reg   <= '0;
            bresp_reg   <= RESP_OKAY;
        end else begin
            if (aw_hs) begin
                aw_held_reg <= 1'b1;
                aw_idx_reg  <= s_axi_lite_awaddr[ADDR_WIDTH-1:2];
            end
            if (w_hs) begin
                w_held_reg <= 1'b1;
                wdata_reg  <= s_axi_lite_wdata;
            end
            if (wr_commit) bresp_reg <= wr_mapped ? RESP_OKAY : RESP_UNMAPPED;
            if (b_hs) begin
                aw_held_reg <= 1'b0;
                w_held_reg  <= 1'b0;
            end
        end
    end

    assign s_axi_lite_bresp = bresp_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            localparam logic [IDX_W-1:0] GI_IDX = IDX_W'(gi);
            logic [DATA_WIDTH-1:0] value_reg;
            logic                  pulse_reg;

            // Register gi loads on a commit that targets it; the status slot is never storable
            always_ff @(posedge axi_aclk) begin
                if (axi_reset) begin
                    value_reg <= '0;
                    pulse_reg <= 1'b0;
                end else if (wr_commit && wr_writable && (aw_idx_reg == GI_IDX)) begin
                    value_reg <= wdata_reg;
                    pulse_reg <= 1'b1;
                end else begin
                    pulse_reg <= 1'b0;
                end
            end

            assign regs_rd[gi]                            = value_reg;
            assign regs_o[gi*DATA_WIDTH +: DATA_WIDTH] = value_reg;
            assign wr_pulse_o[gi]                         = pulse_reg;
        end
    endgenerate

    assign rd_idx    = s_axi_lite_araddr[ADDR_WIDTH-1:2];
    assign rd_mapped = {1'b0, rd_idx} < NUM_REGS_W;

    // Read source select: live status, stored register, or zero for unmapped words
    always_comb begin
        rd_value = '0;
        rd_resp  = RESP_UNMAPPED;
        if (rd_idx == STATUS_W) begin
            rd_value = status_i;
            rd_resp  = RESP_OKAY;
        end else if (rd_mapped) begin
            rd_value = regs_rd[rd_idx[REG_IDX_W-1:0]];
            rd_resp  = RESP_OKAY;
        end
    end

    // Read FSM state register
    always_ff @(posedge axi_aclk) begin
        if (axi_reset) rd_state_reg <= RD_IDLE;
        else           rd_state_reg <= rd_state_next;
    end

    // Read FSM next state: one read in flight, released by rready
    always_comb begin
        rd_state_next = rd_state_reg;
        case (rd_state_reg)
            RD_IDLE: if (ar_hs) rd_state_next = RD_RESP;
            RD_RESP: if (s_axi_lite_rready) rd_state_next = RD_IDLE;
            default: rd_state_next = RD_IDLE;
        endcase
    end

    // Read FSM outputs
    always_comb begin
        s_axi_lite_arready = (rd_state_reg == RD_IDLE);
        s_axi_lite_rvalid  = (rd_state_reg == RD_RESP);
    end

    // Read data capture: snapshot at the AR handshake, so a same-edge commit is not visible
    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            rdata_reg <= '0;
            rresp_reg <= RESP_OKAY;
        end else if (ar_hs) begin
            rdata_reg <= rd_value;
            rresp_reg <= rd_resp;
        end
    end

    assign s_axi_lite_rdata = rdata_reg;
    assign s_axi_lite_rresp = rresp_reg;

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// tb_axi_lite_reg_slave
// Randomised and directed AXI4-Lite traffic against a register-file model.
// The model is an array of words updated by the address-map rules.
// Honours AXIL_SLVERR_EN when computing expected response codes.
module tb_axi_lite_reg_slave;

    logic         axi_aclk = 1'b0;
    logic         axi_reset;
    logic         s_axi_lite_awvalid;
    logic         s_axi_lite_awready;
    logic [9:0]   s_axi_lite_awaddr;
    logic         s_axi_lite_wvalid;
    logic         s_axi_lite_wready;
    logic [31:0]  s_axi_lite_wdata;
    logic [1:0]   s_axi_lite_bresp;
    logic         s_axi_lite_bvalid;
    logic         s_axi_lite_bready;
    logic         s_axi_lite_arvalid;
    logic         s_axi_lite_arready;
    logic [9:0]   s_axi_lite_araddr;
    logic         s_axi_lite_rvalid;
    logic         s_axi_lite_rready;
    logic [31:0]  s_axi_lite_rdata;
    logic [1:0]   s_axi_lite_rresp;
    logic [31:0]  status_i;
    logic [511:0] regs_o;
    logic [15:0]  wr_pulse_o;

`ifdef AXIL_SLVERR_EN
    localparam logic [1:0] UNMAPPED_RESP = 2'b10;
`else
    localparam logic [1:0] UNMAPPED_RESP = 2'b00;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] model_regs [16];

    axi_lite_reg_slave dut (
        .axi_aclk           (axi_aclk),
        .axi_reset          (axi_reset),
        .s_axi_lite_awvalid (s_axi_lite_awvalid),
        .s_axi_lite_awready (s_axi_lite_awready),
        .s_axi_lite_awaddr  (s_axi_lite_awaddr),
        .s_axi_lite_wvalid  (s_axi_lite_wvalid),
        .s_axi_lite_wready  (s_axi_lite_wready),
        .s_axi_lite_wdata   (s_axi_lite_wdata),
        .s_axi_lite_bresp   (s_axi_lite_bresp),
        .s_axi_lite_bvalid  (s_axi_lite_bvalid),
        .s_axi_lite_bready  (s_axi_lite_bready),
        .s_axi_lite_arvalid (s_axi_lite_arvalid),
        .s_axi_lite_arready (s_axi_lite_arready),
        .s_axi_lite_araddr  (s_axi_lite_araddr),
        .s_axi_lite_rvalid  (s_axi_lite_rvalid),
        .s_axi_lite_rready  (s_axi_lite_rready),
        .s_axi_lite_rdata   (s_axi_lite_rdata),
        .s_axi_lite_rresp   (s_axi_lite_rresp),
        .status_i           (status_i),
        .regs_o             (regs_o),
        .wr_pulse_o         (wr_pulse_o)
    );

    always #5 axi_aclk = ~axi_aclk;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [1:0] resp_for(input int idx);
        return (idx >= 16) ? UNMAPPED_RESP : 2'b00;
    endfunction

    function automatic bit storable(input int idx);
        return (idx < 16) && (idx != 1);
    endfunction

    function automatic logic [31:0] read_value(input int idx);
        if (idx == 1) return status_i;
        if (idx < 16) return model_regs[idx];
        return 32'h0;
    endfunction

    function automatic logic [511:0] model_flat();
        logic [511:0] f;
        f = '0;
        for (int i = 0; i < 16; i++) f[i*32 +: 32] = model_regs[i];
        return f;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 16; i++) model_regs[i] = 32'h0;
    endtask

    task automatic do_reset();
        axi_reset = 1'b1;
        repeat (3) @(negedge axi_aclk);
        axi_reset = 1'b0;
        model_clear();
    endtask

    // One write transaction; starts and ends on a falling edge.
    task automatic axi_write(input logic [9:0] addr, input logic [31:0] data,
                             input int aw_dly, input int w_dly, input int b_dly);
        int idx, hs_edge, bv_cyc, pulse_cnt;
        logic [15:0] pulse_or, exp_mask;
        logic [1:0]  exp_resp;
        bit aw_done, w_done, aw_hs, w_hs, b_hs, done, rdy_ok, bp_ok;
        idx       = int'(addr[9:2]);
        exp_resp  = resp_for(idx);
        exp_mask  = storable(idx) ? (16'h1 << idx) : 16'h0;
        hs_edge   = -10;
        bv_cyc    = -1;
        pulse_cnt = 0;
        pulse_or  = '0;
        aw_done   = 0;
        w_done    = 0;
        done      = 0;
        rdy_ok    = 1;
        bp_ok     = 1;
        for (int cyc = 0; cyc < 100 && !done; cyc++) begin
            s_axi_lite_awvalid = !aw_done && (cyc >= aw_dly);
            s_axi_lite_awaddr  = addr;
            s_axi_lite_wvalid  = !w_done && (cyc >= w_dly);
            s_axi_lite_wdata   = data;
            s_axi_lite_bready  = (bv_cyc >= 0) && (cyc - bv_cyc >= b_dly);
            aw_hs = s_axi_lite_awvalid && s_axi_lite_awready;
            w_hs  = s_axi_lite_wvalid && s_axi_lite_wready;
            b_hs  = s_axi_lite_bvalid && s_axi_lite_bready;
            @(negedge axi_aclk);
            if (aw_hs) begin aw_done = 1; hs_edge = cyc; end
            if (w_hs)  begin w_done = 1;  hs_edge = cyc; end
            if (wr_pulse_o != '0) begin
                pulse_cnt++;
                pulse_or |= wr_pulse_o;
            end
            if (b_hs) begin
                done = 1;
                check("wr_release", {s_axi_lite_bvalid, s_axi_lite_awready, s_axi_lite_wready}, 3'b011);
            end else if (s_axi_lite_bvalid) begin
                if (bv_cyc < 0) begin
                    bv_cyc = cyc + 1;
                    // bvalid rises one clock after the later handshake edge,
                    // which is two falling edges after that handshake.
                    check("wr_latency", bv_cyc - hs_edge, 2);
                    check("wr_bresp", s_axi_lite_bresp, exp_resp);
                end
                if (s_axi_lite_awready || s_axi_lite_wready || s_axi_lite_bresp != exp_resp) bp_ok = 0;
            end else begin
                if (aw_done && s_axi_lite_awready) rdy_ok = 0;
                if (w_done && s_axi_lite_wready) rdy_ok = 0;
            end
        end
        s_axi_lite_awvalid = 1'b0;
        s_axi_lite_wvalid  = 1'b0;
        s_axi_lite_bready  = 1'b0;
        check("wr_done", done, 1);
        check("wr_ready_low", rdy_ok, 1);
        check("wr_backpressure", bp_ok, 1);
        check("wr_pulse_count", pulse_cnt, (exp_mask != 0) ? 1 : 0);
        check("wr_pulse_mask", pulse_or, exp_mask);
        if (storable(idx)) model_regs[idx] = data;
        check("wr_regs_o", regs_o, model_flat());
        $display("WR addr=%03h data=%08h aw_dly=%0d w_dly=%0d b_dly=%0d bresp=%0d",
                 addr, data, aw_dly, w_dly, b_dly, s_axi_lite_bresp);
    endtask

    // One read transaction; the caller supplies the expected data and response.
    task automatic axi_read(input logic [9:0] addr, input int ar_dly, input int r_dly,
                            input logic [31:0] exp_data, input logic [1:0] exp_resp);
        int hs_edge, rv_cyc;
        logic [31:0] first_data;
        logic [1:0]  first_resp;
        bit ar_done, ar_hs, r_hs, done, stable_ok;
        hs_edge    = -10;
        rv_cyc     = -1;
        ar_done    = 0;
        done       = 0;
        stable_ok  = 1;
        first_data = '0;
        first_resp = '0;
        for (int cyc = 0; cyc < 100 && !done; cyc++) begin
            s_axi_lite_arvalid = !ar_done && (cyc >= ar_dly);
            s_axi_lite_araddr  = addr;
            s_axi_lite_rready  = (rv_cyc >= 0) && (cyc - rv_cyc >= r_dly);
            ar_hs = s_axi_lite_arvalid && s_axi_lite_arready;
            r_hs  = s_axi_lite_rvalid && s_axi_lite_rready;
            @(negedge axi_aclk);
            if (ar_hs) begin ar_done = 1; hs_edge = cyc; end
            if (r_hs) begin
                done = 1;
                check("rd_release", {s_axi_lite_rvalid, s_axi_lite_arready}, 2'b01);
            end else if (s_axi_lite_rvalid) begin
                if (rv_cyc < 0) begin
                    rv_cyc     = cyc + 1;
                    first_data = s_axi_lite_rdata;
                    first_resp = s_axi_lite_rresp;
                    check("rd_latency", rv_cyc - hs_edge, 1);
                    check("rd_data", s_axi_lite_rdata, exp_data);
                    check("rd_resp", s_axi_lite_rresp, exp_resp);
                end
                if (s_axi_lite_rdata != first_data || s_axi_lite_rresp != first_resp ||
                    s_axi_lite_arready) stable_ok = 0;
            end
        end
        s_axi_lite_arvalid = 1'b0;
        s_axi_lite_rready  = 1'b0;
        check("rd_done", done, 1);
        check("rd_stable", stable_ok, 1);
        $display("RD addr=%03h rdata=%08h rresp=%0d ar_dly=%0d r_dly=%0d",
                 addr, first_data, first_resp, ar_dly, r_dly);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int bv_seen;
        s_axi_lite_awvalid = 1'b0;
        s_axi_lite_awaddr  = '0;
        s_axi_lite_wvalid  = 1'b0;
        s_axi_lite_wdata   = '0;
        s_axi_lite_bready  = 1'b0;
        s_axi_lite_arvalid = 1'b0;
        s_axi_lite_araddr  = '0;
        s_axi_lite_rready  = 1'b0;
        status_i           = 32'h0;
        do_reset();

        // Reset state
        check("rst_handshake", {s_axi_lite_awready, s_axi_lite_wready, s_axi_lite_arready,
                                s_axi_lite_bvalid, s_axi_lite_rvalid}, 5'b11100);
        check("rst_resp", {s_axi_lite_bresp, s_axi_lite_rresp}, 4'b0000);
        check("rst_rdata", s_axi_lite_rdata, 32'h0);
        check("rst_regs", regs_o, 512'h0);
        check("rst_pulse", wr_pulse_o, 16'h0);

        // Write then read
        axi_write(10'h000, 32'h0000_1001, 0, 0, 0);
        axi_read(10'h000, 0, 0, 32'h0000_1001, 2'b00);

        // W three cycles ahead of AW
        axi_write(10'h018, 32'hCAFE_F00D, 3, 0, 0);
        check("reg6", regs_o[6*32 +: 32], 32'hCAFE_F00D);

        // Response back-pressure, then a follow-up write
        axi_write(10'h020, 32'h1234_5678, 0, 1, 5);
        axi_write(10'h024, 32'h8765_4321, 0, 0, 0);

        // Status register: write discarded, read returns live status
        status_i = 32'h0000_0002;
        axi_write(10'h004, 32'hFFFF_FFFF, 0, 0, 0);
        axi_read(10'h004, 0, 0, 32'h0000_0002, 2'b00);
        check("status_reg_storage", regs_o[1*32 +: 32], 32'h0);

        // Unmapped word
        axi_write(10'h3FC, 32'hDEAD_BEEF, 0, 0, 1);
        axi_read(10'h3FC, 0, 2, 32'h0, UNMAPPED_RESP);

        // Commit and AR handshake on the same edge return the old value, held under rready stall
        axi_write(10'h00C, 32'h0000_0055, 0, 0, 0);
        fork
            axi_write(10'h00C, 32'h0000_00AA, 0, 0, 0);
            axi_read(10'h00C, 1, 4, 32'h0000_0055, 2'b00);
        join
        axi_read(10'h00C, 0, 0, 32'h0000_00AA, 2'b00);

        // Randomised traffic
        for (int i = 0; i < 60; i++) begin
            int idx;
            logic [9:0] addr;
            idx  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(16, 255)) : int'($urandom_range(0, 15));
            addr = {8'(idx), 2'($urandom_range(0, 3))};
            status_i = $urandom;
            if ($urandom_range(0, 1) == 0)
                axi_write(addr, $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 3)));
            else
                axi_read(addr, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                         read_value(idx), resp_for(idx));
        end

        // Reset between AW capture and W
        s_axi_lite_awvalid = 1'b1;
        s_axi_lite_awaddr  = 10'h008;
        @(negedge axi_aclk);
        s_axi_lite_awvalid = 1'b0;
        check("midrst_aw_taken", s_axi_lite_awready, 1'b0);
        axi_reset = 1'b1;
        @(negedge axi_aclk);
        axi_reset = 1'b0;
        model_clear();
        check("midrst_handshake", {s_axi_lite_awready, s_axi_lite_wready, s_axi_lite_arready,
                                   s_axi_lite_bvalid, s_axi_lite_rvalid}, 5'b11100);
        check("midrst_regs", regs_o, model_flat());
        check("midrst_pulse", wr_pulse_o, 16'h0);
        check("midrst_resp", {s_axi_lite_bresp, s_axi_lite_rresp, s_axi_lite_rdata}, 36'h0);
        s_axi_lite_wvalid = 1'b1;
        s_axi_lite_wdata  = 32'h0BAD_0BAD;
        @(negedge axi_aclk);
        s_axi_lite_wvalid = 1'b0;
        bv_seen = 0;
        repeat (6) begin
            @(negedge axi_aclk);
            if (s_axi_lite_bvalid) bv_seen = 1;
        end
        check("midrst_no_bvalid", bv_seen, 0);
        check("midrst_regs_after_w", regs_o, model_flat());
        $display("RST mid-write: bvalid_seen=%0d", bv_seen);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
